// File: rtl/axi_lite_arbiter_2x1_if.sv
// AXI-lite channel bundle shared by both sides of the arbiter.
// M modport: drives a slave (request valids, payloads, response readys).
// S modport: faces a master (request readys, response valids and payloads).
interface if_axi_lite #(
  parameter int AXILADDRLEN = 32,
  parameter int AXILDATALEN = 32
);
  logic                       awvalid;
  logic                       awready;
  logic [AXILADDRLEN-1:0]     awaddr;
  logic [2:0]                 awprot;
  logic                       wvalid;
  logic                       wready;
  logic [AXILDATALEN-1:0]     wdata;
  logic [AXILDATALEN/8-1:0]   wstrb;
  logic                       bvalid;
  logic                       bready;
  logic [1:0]                 bresp;
  logic                       arvalid;
  logic                       arready;
  logic [AXILADDRLEN-1:0]     araddr;
  logic [2:0]                 arprot;
  logic                       rvalid;
  logic                       rready;
  logic [AXILDATALEN-1:0]     rdata;
  logic [1:0]                 rresp;

  modport M (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport S (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_arbiter_2x1.sv
// Purpose: shares one AXI-lite slave (m) between two masters (s0, s1); write and
//   read paths each round-robin arbitrated with one transaction outstanding.
// Latency: request in IDLE at N -> m-side valid at N+1; one idle bubble per transaction.
// Backpressure: losing/non-granted master sees all readys/valids low and stalls.
// Ports: aclk/areset (async, active high); s0/s1 upstream (S modport);
//   m downstream (M modport); wr_grant/wr_busy, rd_grant/rd_busy status.
module axi_lite_arbiter_2x1 #(
  parameter int AXILADDRLEN = 32,
  parameter int AXILDATALEN = 32
) (
  input  logic       aclk,
  input  logic       areset,
  if_axi_lite.S      s0,
  if_axi_lite.S      s1,
  if_axi_lite.M      m,
  output logic       wr_grant,
  output logic       wr_busy,
  output logic       rd_grant,
  output logic       rd_busy
);
  localparam int STRBLEN = AXILDATALEN / 8;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

  wr_state_t r_wr_state, w_wr_state_nxt;
  rd_state_t r_rd_state, w_rd_state_nxt;
  logic r_wr_grant, w_wr_grant_nxt, r_wr_last, w_wr_last_nxt;
  logic r_rd_grant, w_rd_grant_nxt, r_rd_last, w_rd_last_nxt;
  logic r_aw_done, w_aw_done_nxt, r_w_done, w_w_done_nxt;

  // Granted-master views of the request side and the handshake outputs before demux.
  logic w_g_awvalid, w_g_wvalid, w_g_bready, w_g_arvalid, w_g_rready;
  logic w_g_awready, w_g_wready, w_g_bvalid, w_g_arready, w_g_rvalid;
  logic w_m_awvalid, w_m_wvalid, w_m_bready, w_m_arvalid, w_m_rready;

  logic [AXILADDRLEN-1:0] w_awaddr, w_araddr;
  logic [AXILDATALEN-1:0] w_wdata;
  logic [STRBLEN-1:0]     w_wstrb;

  // Payload muxes follow the registered grant, which is frozen outside IDLE,
  // so m-side payloads cannot change while an m-side valid is high.
  assign w_awaddr  = r_wr_grant ? s1.awaddr : s0.awaddr;
  assign w_wdata   = r_wr_grant ? s1.wdata  : s0.wdata;
  assign w_wstrb   = r_wr_grant ? s1.wstrb  : s0.wstrb;
  assign w_araddr  = r_rd_grant ? s1.araddr : s0.araddr;

  assign m.awaddr  = w_awaddr;
  assign m.awprot  = r_wr_grant ? s1.awprot : s0.awprot;
  assign m.wdata   = w_wdata;
  assign m.wstrb   = w_wstrb;
  assign m.araddr  = w_araddr;
  assign m.arprot  = r_rd_grant ? s1.arprot : s0.arprot;

  assign w_g_awvalid = r_wr_grant ? s1.awvalid : s0.awvalid;
  assign w_g_wvalid  = r_wr_grant ? s1.wvalid  : s0.wvalid;
  assign w_g_bready  = r_wr_grant ? s1.bready  : s0.bready;
  assign w_g_arvalid = r_rd_grant ? s1.arvalid : s0.arvalid;
  assign w_g_rready  = r_rd_grant ? s1.rready  : s0.rready;

  assign m.awvalid = w_m_awvalid;
  assign m.wvalid  = w_m_wvalid;
  assign m.bready  = w_m_bready;
  assign m.arvalid = w_m_arvalid;
  assign m.rready  = w_m_rready;

  // Only the granted master ever sees a ready or a response valid.
  assign s0.awready = w_g_awready & ~r_wr_grant;
  assign s1.awready = w_g_awready &  r_wr_grant;
  assign s0.wready  = w_g_wready  & ~r_wr_grant;
  assign s1.wready  = w_g_wready  &  r_wr_grant;
  assign s0.bvalid  = w_g_bvalid  & ~r_wr_grant;
  assign s1.bvalid  = w_g_bvalid  &  r_wr_grant;
  assign s0.arready = w_g_arready & ~r_rd_grant;
  assign s1.arready = w_g_arready &  r_rd_grant;
  assign s0.rvalid  = w_g_rvalid  & ~r_rd_grant;
  assign s1.rvalid  = w_g_rvalid  &  r_rd_grant;

  assign s0.bresp = m.bresp;
  assign s1.bresp = m.bresp;
  assign s0.rdata = m.rdata;
  assign s1.rdata = m.rdata;
  assign s0.rresp = m.rresp;
  assign s1.rresp = m.rresp;

  assign wr_grant = r_wr_grant;
  assign wr_busy  = (r_wr_state != W_IDLE);
  assign rd_grant = r_rd_grant;
  assign rd_busy  = (r_rd_state != R_IDLE);

  // r_*_last holds the last served master; it resets to 1 so a tie out of
  // reset goes to s0.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wr_state <= W_IDLE;
      r_wr_grant <= 1'b0;
      r_wr_last  <= 1'b1;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_rd_state <= R_IDLE;
      r_rd_grant <= 1'b0;
      r_rd_last  <= 1'b1;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_wr_grant <= w_wr_grant_nxt;
      r_wr_last  <= w_wr_last_nxt;
      r_aw_done  <= w_aw_done_nxt;
      r_w_done   <= w_w_done_nxt;
      r_rd_state <= w_rd_state_nxt;
      r_rd_grant <= w_rd_grant_nxt;
      r_rd_last  <= w_rd_last_nxt;
    end
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_grant_nxt = r_wr_grant;
    w_wr_last_nxt  = r_wr_last;
    w_aw_done_nxt  = r_aw_done;
    w_w_done_nxt   = r_w_done;
    w_m_awvalid    = 1'b0;
    w_m_wvalid     = 1'b0;
    w_m_bready     = 1'b0;
    w_g_awready    = 1'b0;
    w_g_wready     = 1'b0;
    w_g_bvalid     = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        if (s0.awvalid | s1.awvalid) begin
          w_wr_grant_nxt = (s0.awvalid & s1.awvalid) ? ~r_wr_last : s1.awvalid;
          w_aw_done_nxt  = 1'b0;
          w_w_done_nxt   = 1'b0;
          w_wr_state_nxt = W_ADDR;
        end
      end
      W_ADDR: begin
        // AW and W complete independently; each is masked once it has handshaken.
        w_m_awvalid   = w_g_awvalid & ~r_aw_done;
        w_m_wvalid    = w_g_wvalid  & ~r_w_done;
        w_g_awready   = m.awready   & ~r_aw_done;
        w_g_wready    = m.wready    & ~r_w_done;
        w_aw_done_nxt = r_aw_done | (w_m_awvalid & m.awready);
        w_w_done_nxt  = r_w_done  | (w_m_wvalid  & m.wready);
        if (w_aw_done_nxt & w_w_done_nxt) w_wr_state_nxt = W_RESP;
      end
      W_RESP: begin
        w_m_bready = w_g_bready;
        w_g_bvalid = m.bvalid;
        if (m.bvalid & w_g_bready) begin
          w_wr_state_nxt = W_IDLE;
          w_wr_last_nxt  = r_wr_grant;
        end
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_grant_nxt = r_rd_grant;
    w_rd_last_nxt  = r_rd_last;
    w_m_arvalid    = 1'b0;
    w_m_rready     = 1'b0;
    w_g_arready    = 1'b0;
    w_g_rvalid     = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        if (s0.arvalid | s1.arvalid) begin
          w_rd_grant_nxt = (s0.arvalid & s1.arvalid) ? ~r_rd_last : s1.arvalid;
          w_rd_state_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        w_m_arvalid = w_g_arvalid;
        w_g_arready = m.arready;
        if (w_g_arvalid & m.arready) w_rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        w_m_rready = w_g_rready;
        w_g_rvalid = m.rvalid;
        if (m.rvalid & w_g_rready) begin
          w_rd_state_nxt = R_IDLE;
          w_rd_last_nxt  = r_rd_grant;
        end
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi_lite_arbiter_2x1.sv
// Bench for axi_lite_arbiter_2x1: directed scenarios with literal expectations,
// plus a transaction-level ownership model compared against the DUT every cycle.
module tb_axi_lite_arbiter_2x1;
  logic aclk = 1'b0;
  logic areset;
  logic wr_grant, wr_busy, rd_grant, rd_busy;

  if_axi_lite #(.AXILADDRLEN(32), .AXILDATALEN(32)) s0_if ();
  if_axi_lite #(.AXILADDRLEN(32), .AXILDATALEN(32)) s1_if ();
  if_axi_lite #(.AXILADDRLEN(32), .AXILDATALEN(32)) m_if ();

  axi_lite_arbiter_2x1 #(.AXILADDRLEN(32), .AXILDATALEN(32)) dut (
    .aclk(aclk), .areset(areset), .s0(s0_if), .s1(s1_if), .m(m_if),
    .wr_grant(wr_grant), .wr_busy(wr_busy), .rd_grant(rd_grant), .rd_busy(rd_busy)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Upstream signal access by master index.
  function automatic logic g_awvalid(input logic k); return k ? s1_if.awvalid : s0_if.awvalid; endfunction
  function automatic logic g_wvalid(input logic k);  return k ? s1_if.wvalid  : s0_if.wvalid;  endfunction
  function automatic logic g_bready(input logic k);  return k ? s1_if.bready  : s0_if.bready;  endfunction
  function automatic logic g_arvalid(input logic k); return k ? s1_if.arvalid : s0_if.arvalid; endfunction
  function automatic logic g_rready(input logic k);  return k ? s1_if.rready  : s0_if.rready;  endfunction
  function automatic logic g_bvalid(input logic k);  return k ? s1_if.bvalid  : s0_if.bvalid;  endfunction
  function automatic logic g_rvalid(input logic k);  return k ? s1_if.rvalid  : s0_if.rvalid;  endfunction
  function automatic logic [34:0] g_aw(input logic k);
    return k ? {s1_if.awaddr, s1_if.awprot} : {s0_if.awaddr, s0_if.awprot};
  endfunction
  function automatic logic [35:0] g_w(input logic k);
    return k ? {s1_if.wdata, s1_if.wstrb} : {s0_if.wdata, s0_if.wstrb};
  endfunction
  function automatic logic [34:0] g_ar(input logic k);
    return k ? {s1_if.araddr, s1_if.arprot} : {s0_if.araddr, s0_if.arprot};
  endfunction
  function automatic logic [1:0] g_bresp(input logic k); return k ? s1_if.bresp : s0_if.bresp; endfunction
  function automatic logic [33:0] g_r(input logic k);
    return k ? {s1_if.rdata, s1_if.rresp} : {s0_if.rdata, s0_if.rresp};
  endfunction

  // Model: who owns each path, what that owner still has to hand over, and who
  // wins the next tie (the master that was not served last).
  bit w_act, w_who, w_need_aw, w_need_w, w_in_resp, w_tie;
  bit r_act, r_who, r_in_data, r_tie;

  always @(negedge aclk) begin
    logic e_m_awv, e_m_wv, e_m_bry, e_m_arv, e_m_rry;
    logic [1:0] e_awr, e_wr, e_bv, e_arr, e_rv;
    if (areset) begin
      chk("rst_outputs",
          {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready,
           s0_if.awready, s0_if.wready, s0_if.bvalid, s0_if.arready, s0_if.rvalid,
           s1_if.awready, s1_if.wready, s1_if.bvalid, s1_if.arready, s1_if.rvalid,
           wr_busy, rd_busy, wr_grant, rd_grant}, 64'd0);
      w_act = 0; w_tie = 0; r_act = 0; r_tie = 0;
      w_need_aw = 0; w_need_w = 0; w_in_resp = 0; r_in_data = 0; w_who = 0; r_who = 0;
    end else begin
      e_m_awv = 0; e_m_wv = 0; e_m_bry = 0; e_m_arv = 0; e_m_rry = 0;
      e_awr = 0; e_wr = 0; e_bv = 0; e_arr = 0; e_rv = 0;
      if (w_act && !w_in_resp) begin
        e_m_awv = g_awvalid(w_who) && w_need_aw;
        e_m_wv  = g_wvalid(w_who) && w_need_w;
        e_awr[w_who] = m_if.awready && w_need_aw;
        e_wr[w_who]  = m_if.wready && w_need_w;
      end
      if (w_act && w_in_resp) begin
        e_m_bry = g_bready(w_who);
        e_bv[w_who] = m_if.bvalid;
      end
      if (r_act && !r_in_data) begin
        e_m_arv = g_arvalid(r_who);
        e_arr[r_who] = m_if.arready;
      end
      if (r_act && r_in_data) begin
        e_m_rry = g_rready(r_who);
        e_rv[r_who] = m_if.rvalid;
      end
      chk("wr_ctl",
          {m_if.awvalid, m_if.wvalid, m_if.bready, s1_if.awready, s1_if.wready, s1_if.bvalid,
           s0_if.awready, s0_if.wready, s0_if.bvalid, wr_busy},
          {e_m_awv, e_m_wv, e_m_bry, e_awr[1], e_wr[1], e_bv[1], e_awr[0], e_wr[0], e_bv[0], w_act});
      chk("rd_ctl",
          {m_if.arvalid, m_if.rready, s1_if.arready, s1_if.rvalid, s0_if.arready, s0_if.rvalid, rd_busy},
          {e_m_arv, e_m_rry, e_arr[1], e_rv[1], e_arr[0], e_rv[0], r_act});
      chk("ready_mutex",
          {s0_if.awready & s1_if.awready, s0_if.wready & s1_if.wready, s0_if.bvalid & s1_if.bvalid,
           s0_if.arready & s1_if.arready, s0_if.rvalid & s1_if.rvalid}, 64'd0);
      if (w_act) chk("wr_grant", wr_grant, w_who);
      if (r_act) chk("rd_grant", rd_grant, r_who);
      if (e_m_awv) chk("m_aw_payload", {m_if.awaddr, m_if.awprot}, g_aw(w_who));
      if (e_m_wv)  chk("m_w_payload", {m_if.wdata, m_if.wstrb}, g_w(w_who));
      if (e_m_arv) chk("m_ar_payload", {m_if.araddr, m_if.arprot}, g_ar(r_who));
      if (w_act && e_bv[w_who]) chk("s_bresp", g_bresp(w_who), m_if.bresp);
      if (r_act && e_rv[r_who]) chk("s_rdata", g_r(r_who), {m_if.rdata, m_if.rresp});

      // Advance the model to what must hold after the coming rising edge.
      if (!w_act) begin
        if (g_awvalid(0) || g_awvalid(1)) begin
          w_act = 1;
          w_who = (g_awvalid(0) && g_awvalid(1)) ? w_tie : !g_awvalid(0);
          w_need_aw = 1; w_need_w = 1; w_in_resp = 0;
        end
      end else if (!w_in_resp) begin
        if (e_m_awv && m_if.awready) w_need_aw = 0;
        if (e_m_wv && m_if.wready) w_need_w = 0;
        if (!w_need_aw && !w_need_w) w_in_resp = 1;
      end else if (m_if.bvalid && g_bready(w_who)) begin
        w_tie = !w_who;
        w_act = 0;
      end
      if (!r_act) begin
        if (g_arvalid(0) || g_arvalid(1)) begin
          r_act = 1;
          r_who = (g_arvalid(0) && g_arvalid(1)) ? r_tie : !g_arvalid(0);
          r_in_data = 0;
        end
      end else if (!r_in_data) begin
        if (e_m_arv && m_if.arready) r_in_data = 1;
      end else if (m_if.rvalid && g_rready(r_who)) begin
        r_tie = !r_who;
        r_act = 0;
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic clr_inputs();
    s0_if.awvalid = 0; s0_if.awaddr = 0; s0_if.awprot = 0; s0_if.wvalid = 0; s0_if.wdata = 0;
    s0_if.wstrb = 0; s0_if.bready = 0; s0_if.arvalid = 0; s0_if.araddr = 0; s0_if.arprot = 0;
    s0_if.rready = 0;
    s1_if.awvalid = 0; s1_if.awaddr = 0; s1_if.awprot = 0; s1_if.wvalid = 0; s1_if.wdata = 0;
    s1_if.wstrb = 0; s1_if.bready = 0; s1_if.arvalid = 0; s1_if.araddr = 0; s1_if.arprot = 0;
    s1_if.rready = 0;
    m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0; m_if.bresp = 0; m_if.arready = 0;
    m_if.rvalid = 0; m_if.rdata = 0; m_if.rresp = 0;
  endtask

  bit rr_win [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_inputs();
    areset = 1'b1;
    step();
    step();
    areset = 1'b0;
    #1;
    chk("reset_busy", {wr_busy, rd_busy, wr_grant, rd_grant}, 64'd0);

    // Single write from s0; slave ready immediately, B one cycle after AW/W.
    s0_if.awaddr = 32'h100; s0_if.awvalid = 1; s0_if.wdata = 32'hDEADBEEF; s0_if.wstrb = 4'hF;
    s0_if.wvalid = 1; s0_if.bready = 1; m_if.awready = 1; m_if.wready = 1;
    #1;
    chk("t1_awvalid_at_n", m_if.awvalid, 0);
    step();
    chk("t1_awvalid_at_n1", m_if.awvalid, 1);
    chk("t1_awaddr", m_if.awaddr, 32'h100);
    chk("t1_wdata", m_if.wdata, 32'hDEADBEEF);
    step();
    s0_if.awvalid = 0; s0_if.wvalid = 0; m_if.bvalid = 1; m_if.bresp = 2'b00;
    #1;
    chk("t1_s0_bvalid", s0_if.bvalid, 1);
    chk("t1_s0_bresp", s0_if.bresp, 0);
    step();
    m_if.bvalid = 0;
    #1;
    chk("t1_wr_busy_after", wr_busy, 0);
    clr_inputs();
    step();

    // Both masters keep requesting reads: service order s0, s1, s0.
    m_if.arready = 1; s0_if.rready = 1; s1_if.rready = 1;
    s0_if.araddr = 32'h10; s1_if.araddr = 32'h20;
    s0_if.arvalid = 1; s1_if.arvalid = 1;
    for (int r = 0; r < 3; r++) begin
      step();
      chk("t2_rd_grant", rd_grant, rr_win[r]);
      chk("t2_araddr", m_if.araddr, rr_win[r] ? 32'h20 : 32'h10);
      step();
      if (rr_win[r]) s1_if.arvalid = 0; else s0_if.arvalid = 0;
      m_if.rvalid = 1; m_if.rdata = 32'hA000 + r;
      #1;
      chk("t2_winner_rvalid", g_rvalid(rr_win[r]), 1);
      chk("t2_loser_rvalid", g_rvalid(!rr_win[r]), 0);
      step();
      m_if.rvalid = 0;
      if (rr_win[r]) s1_if.arvalid = 1; else s0_if.arvalid = 1;
    end
    clr_inputs();
    step();

    // W accepted three cycles before AW.
    s0_if.awaddr = 32'h300; s0_if.awvalid = 1; s0_if.wdata = 32'h12345678; s0_if.wstrb = 4'h3;
    s0_if.wvalid = 1; s0_if.bready = 1; m_if.awready = 0; m_if.wready = 1;
    step();
    chk("t3_wready_first", s0_if.wready, 1);
    chk("t3_awready_first", s0_if.awready, 0);
    step();
    s0_if.wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) m_if.awready = 1;
      #1;
      chk("t3_wready_once", s0_if.wready, 0);
      chk("t3_not_in_resp", m_if.bready, 0);
      if (i < 2) step();
    end
    chk("t3_awready_late", s0_if.awready, 1);
    step();
    s0_if.awvalid = 0; m_if.bvalid = 1;
    #1;
    chk("t3_resp_entered", s0_if.bvalid, 1);
    step();
    clr_inputs();
    step();

    // s0 write and s1 read in flight together; B and R return in the same cycle.
    s0_if.awaddr = 32'h400; s0_if.awvalid = 1; s0_if.wdata = 32'h55; s0_if.wstrb = 4'hF;
    s0_if.wvalid = 1; s0_if.bready = 1;
    s1_if.araddr = 32'h80; s1_if.arvalid = 1; s1_if.rready = 1;
    m_if.awready = 1; m_if.wready = 1; m_if.arready = 1;
    step();
    chk("t4_grants", {wr_busy, wr_grant, rd_busy, rd_grant}, 64'b1011);
    step();
    s0_if.awvalid = 0; s0_if.wvalid = 0; s1_if.arvalid = 0;
    m_if.bvalid = 1; m_if.bresp = 2'b10; m_if.rvalid = 1; m_if.rdata = 32'hCAFEF00D;
    #1;
    chk("t4_resp_routing", {s0_if.bvalid, s1_if.bvalid, s0_if.rvalid, s1_if.rvalid}, 64'b1001);
    chk("t4_s0_bresp", s0_if.bresp, 2'b10);
    chk("t4_s1_rdata", s1_if.rdata, 32'hCAFEF00D);
    step();
    m_if.bvalid = 0; m_if.rvalid = 0;
    #1;
    chk("t4_both_idle", {wr_busy, rd_busy}, 0);
    clr_inputs();
    step();

    // B held by s0 (bready low 5 cycles); s1 write waits for the B handshake.
    s0_if.awaddr = 32'h500; s0_if.awvalid = 1; s0_if.wvalid = 1; s0_if.wstrb = 4'hF;
    s0_if.bready = 0; m_if.awready = 1; m_if.wready = 1;
    step();
    step();
    s0_if.awvalid = 0; s0_if.wvalid = 0; m_if.bvalid = 1;
    s1_if.awaddr = 32'h200; s1_if.awvalid = 1; s1_if.wdata = 32'h77; s1_if.wstrb = 4'hF;
    s1_if.wvalid = 1; s1_if.bready = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_hold_grant", {wr_busy, wr_grant}, 64'b10);
      chk("t5_s1_stalled", s1_if.awready, 0);
      chk("t5_s0_bvalid", s0_if.bvalid, 1);
      step();
    end
    s0_if.bready = 1;
    #1;
    chk("t5_bready_pass", m_if.bready, 1);
    step();
    m_if.bvalid = 0;
    #1;
    chk("t5_bubble", wr_busy, 0);
    step();
    chk("t5_s1_granted", wr_grant, 1);
    chk("t5_s1_awaddr", m_if.awaddr, 32'h200);
    step();
    s1_if.awvalid = 0; s1_if.wvalid = 0; m_if.bvalid = 1;
    #1;
    chk("t5_s1_bvalid", {s1_if.bvalid, s0_if.bvalid}, 64'b10);
    step();
    clr_inputs();
    step();

    // Reset while in R_DATA, then a fresh s1 read.
    s0_if.araddr = 32'h30; s0_if.arvalid = 1; s0_if.rready = 1; m_if.arready = 1;
    step();
    step();
    s0_if.arvalid = 0; m_if.rvalid = 1; m_if.rdata = 32'h99;
    #1;
    chk("t6_pre_reset_rvalid", s0_if.rvalid, 1);
    areset = 1'b1;
    #1;
    chk("t6_reset_drop", {m_if.rready, s0_if.rvalid, s1_if.rvalid, rd_busy}, 0);
    step();
    areset = 1'b0; m_if.rvalid = 0;
    s1_if.araddr = 32'h40; s1_if.arvalid = 1; s1_if.rready = 1;
    step();
    chk("t6_s1_grant", rd_grant, 1);
    chk("t6_s1_araddr", m_if.araddr, 32'h40);
    step();
    s1_if.arvalid = 0; m_if.rvalid = 1; m_if.rdata = 32'h4444;
    #1;
    chk("t6_s1_rdata", {s1_if.rvalid, s1_if.rdata}, {1'b1, 32'h4444});
    step();
    m_if.rvalid = 0;
    #1;
    chk("t6_rd_idle", rd_busy, 0);
    clr_inputs();
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
